// File: rtl/fetch_buffer.sv
// Instruction prefetch buffer: keeps a circular queue of 16-bit halfwords ahead of the fetch
// stage and assembles a 32-bit or zero-extended compressed instruction for the presented PC.
module fetch_buffer #(
    parameter int DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetchbuffer_in_mem_valid,
    input  logic        fetchbuffer_in_mem_fence,
    input  logic        fetchbuffer_in_mem_spec,
    input  logic [31:0] fetchbuffer_in_mem_addr,
    output logic        fetchbuffer_out_mem_ready,
    output logic [31:0] fetchbuffer_out_mem_rdata,
    output logic        imem_in_mem_valid,
    output logic        imem_in_mem_instr,
    output logic        imem_in_mem_spec,
    output logic        imem_in_mem_fence,
    output logic [31:0] imem_in_mem_addr,
    output logic [31:0] imem_in_mem_wdata,
    output logic [3:0]  imem_in_mem_wstrb,
    input  logic        imem_out_mem_ready,
    input  logic [31:0] imem_out_mem_rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   buf_q [DEPTH];
    logic [15:0]   buf_d [DEPTH];
    logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   head_addr_q, head_addr_d;
    logic [31:0]   fetch_addr_q, fetch_addr_d;
    logic          pend_q, pend_d, drop_q, drop_d, skip_q, skip_d, init_q, init_d;
    logic          req_valid_q, req_valid_d;
    logic [31:0]   req_addr_q, req_addr_d;

    logic [31:0]   off;
    logic          off_ok;
    logic [1:0]    pop_n;
    logic [CW-1:0] pop_cnt;
    logic          redirect;
    logic          resp;
    logic [AW-1:0] h0_idx, h1_idx;
    logic [15:0]   h0, h1;
    logic          is32, has_h0, has_h1;

    // Distance of the requested PC from the queue head; only 0, 2 or 4 bytes is a sequential fetch.
    assign off      = fetchbuffer_in_mem_addr - head_addr_q;
    assign off_ok   = (off == 32'd0) || (off == 32'd2) || (off == 32'd4);
    assign pop_n    = off[2:1];
    assign pop_cnt  = CW'(pop_n);
    assign redirect = fetchbuffer_in_mem_valid &&
                      (fetchbuffer_in_mem_spec || fetchbuffer_in_mem_fence || !init_q ||
                       !off_ok || (pop_cnt > count_q));
    assign resp     = imem_out_mem_ready && pend_q;

    assign h0_idx = rptr_q + AW'(pop_n);
    assign h1_idx = h0_idx + AW'(1);
    assign h0     = buf_q[h0_idx];
    assign h1     = buf_q[h1_idx];
    assign is32   = (h0[1:0] == 2'b11);
    assign has_h0 = count_q > pop_cnt;
    assign has_h1 = count_q > (pop_cnt + CW'(1));

    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        fetchbuffer_out_mem_ready = 1'b0;
        fetchbuffer_out_mem_rdata = 32'd0;
        if (fetchbuffer_in_mem_valid && !redirect && has_h0 && (!is32 || has_h1)) begin
            fetchbuffer_out_mem_ready = 1'b1;
            fetchbuffer_out_mem_rdata = is32 ? {h1, h0} : {16'h0000, h0};
        end
    end

    always_comb begin
        buf_d        = buf_q;
        rptr_d       = rptr_q;
        wptr_d       = wptr_q;
        count_d      = count_q;
        head_addr_d  = head_addr_q;
        fetch_addr_d = fetch_addr_q;
        pend_d       = pend_q;
        drop_d       = drop_q;
        skip_d       = skip_q;
        init_d       = init_q;
        req_addr_d   = req_addr_q;
        req_valid_d  = 1'b0;

        if (redirect) begin
            // A response landing in this cycle belongs to the old stream and is simply lost.
            count_d      = '0;
            rptr_d       = wptr_q;
            head_addr_d  = fetchbuffer_in_mem_addr;
            fetch_addr_d = {fetchbuffer_in_mem_addr[31:2], 2'b00};
            skip_d       = fetchbuffer_in_mem_addr[1];
            pend_d       = pend_q && !resp;
            drop_d       = pend_q && !resp;
            init_d       = 1'b1;
        end else begin
            if (fetchbuffer_in_mem_valid) begin
                rptr_d      = rptr_q + AW'(pop_n);
                head_addr_d = head_addr_q + off;
                count_d     = count_q - pop_cnt;
            end
            if (resp) begin
                pend_d = 1'b0;
                if (drop_q) begin
                    drop_d = 1'b0;
                end else begin
                    fetch_addr_d = fetch_addr_q + 32'd4;
                    if (skip_q) begin
                        buf_d[wptr_q] = imem_out_mem_rdata[31:16];
                        wptr_d        = wptr_q + AW'(1);
                        count_d       = count_d + CW'(1);
                        skip_d        = 1'b0;
                    end else begin
                        buf_d[wptr_q]           = imem_out_mem_rdata[15:0];
                        buf_d[wptr_q + AW'(1)]  = imem_out_mem_rdata[31:16];
                        wptr_d                  = wptr_q + AW'(2);
                        count_d                 = count_d + CW'(2);
                    end
                end
            end
        end

        // Issue only with room for a full word so a response can never overflow the queue.
        if (!pend_d && init_d && (count_d <= CW'(DEPTH - 2))) begin
            req_valid_d = 1'b1;
            req_addr_d  = fetch_addr_d;
            pend_d      = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rptr_q       <= '0;
            wptr_q       <= '0;
            count_q      <= '0;
            head_addr_q  <= '0;
            fetch_addr_q <= '0;
            pend_q       <= 1'b0;
            drop_q       <= 1'b0;
            skip_q       <= 1'b0;
            init_q       <= 1'b0;
            req_valid_q  <= 1'b0;
            req_addr_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            rptr_q       <= rptr_d;
            wptr_q       <= wptr_d;
            count_q      <= count_d;
            head_addr_q  <= head_addr_d;
            fetch_addr_q <= fetch_addr_d;
            pend_q       <= pend_d;
            drop_q       <= drop_d;
            skip_q       <= skip_d;
            init_q       <= init_d;
            req_valid_q  <= req_valid_d;
            req_addr_q   <= req_addr_d;
        end
    end

    // NOTE: queue storage is not reset; count gates every read, so stale entries are never used.
    always_ff @(posedge clock) begin
        buf_q <= buf_d;
    end

    assign imem_in_mem_valid = req_valid_q;
    assign imem_in_mem_addr  = req_addr_q;
    assign imem_in_mem_instr = 1'b1;
    assign imem_in_mem_spec  = 1'b0;
    assign imem_in_mem_fence = 1'b0;
    assign imem_in_mem_wdata = 32'd0;
    assign imem_in_mem_wstrb = 4'd0;

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: a queue-level model checked every cycle plus directed fetch scenarios
// with hand-computed instruction values.
module tb_fetch_buffer;

    localparam int DEPTH = 8;
    localparam int LAT   = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        fb_valid, fb_fence, fb_spec;
    logic [31:0] fb_addr;
    logic        fb_ready;
    logic [31:0] fb_rdata;
    logic        im_valid, im_instr, im_spec, im_fence;
    logic [31:0] im_addr, im_wdata;
    logic [3:0]  im_wstrb;
    logic        im_ready = 1'b0;
    logic [31:0] im_rdata = 32'd0;

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clock                     (clock),
        .reset                     (reset),
        .fetchbuffer_in_mem_valid  (fb_valid),
        .fetchbuffer_in_mem_fence  (fb_fence),
        .fetchbuffer_in_mem_spec   (fb_spec),
        .fetchbuffer_in_mem_addr   (fb_addr),
        .fetchbuffer_out_mem_ready (fb_ready),
        .fetchbuffer_out_mem_rdata (fb_rdata),
        .imem_in_mem_valid         (im_valid),
        .imem_in_mem_instr         (im_instr),
        .imem_in_mem_spec          (im_spec),
        .imem_in_mem_fence         (im_fence),
        .imem_in_mem_addr          (im_addr),
        .imem_in_mem_wdata         (im_wdata),
        .imem_in_mem_wstrb         (im_wstrb),
        .imem_out_mem_ready        (im_ready),
        .imem_out_mem_rdata        (im_rdata)
    );

    always #5 clock = ~clock;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no result within cycle budget (cycle %0d)", name, cyc);
    endtask

    // Instruction memory: fixed latency, one outstanding request, logs every request.
    logic [31:0] image [logic [31:0]];
    logic [31:0] req_log [$];
    int          req_cyc [logic [31:0]];
    int          resp_cyc [logic [31:0]];
    int          mem_left = 0;
    logic [31:0] mem_pend_addr = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (image.exists(a)) return image[a];
        return {a[15:0] ^ 16'hA5A6, a[15:0] ^ 16'h0013};
    endfunction

    function automatic int count_reqs(input logic [31:0] lo, input logic [31:0] hi);
        int c = 0;
        foreach (req_log[i]) if (req_log[i] >= lo && req_log[i] <= hi) c++;
        return c;
    endfunction

    always begin
        @(posedge clock);
        #1;
        im_ready = 1'b0;
        if (mem_left > 0) begin
            mem_left--;
            if (mem_left == 0) begin
                im_ready = 1'b1;
                im_rdata = mem_word(mem_pend_addr);
                resp_cyc[mem_pend_addr] = cyc;
            end
        end
        @(negedge clock);
        if (im_valid) begin
            req_log.push_back(im_addr);
            req_cyc[im_addr] = cyc;
            mem_pend_addr = im_addr;
            mem_left = LAT;
        end
    end

    // Model: a plain halfword queue with a head address, driven by the buffer's rules.
    logic [15:0] mq [$];
    logic [31:0] m_head = 32'd0, m_fetch = 32'd0;
    bit          m_pend = 0, m_drop = 0, m_skip = 0, m_init = 0;
    logic        exp_req_valid = 1'b0;
    logic [31:0] exp_req_addr = 32'd0;

    always @(negedge clock) begin : model
        logic [31:0] off;
        logic [1:0]  n;
        logic        redir, resp, e_ready;
        logic [31:0] e_rdata;
        logic [15:0] h0;
        e_ready = 1'b0;
        e_rdata = 32'd0;
        redir   = 1'b0;
        if (!reset) begin
            mq.delete();
            m_head = 32'd0; m_fetch = 32'd0;
            m_pend = 0; m_drop = 0; m_skip = 0; m_init = 0;
            exp_req_valid = 1'b0; exp_req_addr = 32'd0;
        end
        check("imem_valid", {31'd0, im_valid}, {31'd0, exp_req_valid});
        check("imem_addr", im_addr, exp_req_addr);
        if (reset && fb_valid) begin
            off = fb_addr - m_head;
            n   = off[2:1];
            redir = fb_spec || fb_fence || !m_init ||
                    !(off == 32'd0 || off == 32'd2 || off == 32'd4) || (int'(n) > mq.size());
            if (!redir) begin
                repeat (int'(n)) void'(mq.pop_front());
                m_head = fb_addr;
                if (mq.size() >= 1) begin
                    h0 = mq[0];
                    if (h0[1:0] != 2'b11) begin
                        e_ready = 1'b1;
                        e_rdata = {16'h0000, h0};
                    end else if (mq.size() >= 2) begin
                        e_ready = 1'b1;
                        e_rdata = {mq[1], h0};
                    end
                end
            end
        end
        check("fetch_ready", {31'd0, fb_ready}, {31'd0, e_ready});
        check("fetch_rdata", fb_rdata, e_rdata);
        if (reset) begin
            resp = im_ready && m_pend;
            if (redir) begin
                mq.delete();
                m_head  = fb_addr;
                m_fetch = {fb_addr[31:2], 2'b00};
                m_skip  = fb_addr[1];
                m_drop  = m_pend && !resp;
                m_pend  = m_pend && !resp;
                m_init  = 1;
            end else if (resp) begin
                m_pend = 0;
                if (m_drop) begin
                    m_drop = 0;
                end else begin
                    if (m_skip) begin
                        mq.push_back(im_rdata[31:16]);
                        m_skip = 0;
                    end else begin
                        mq.push_back(im_rdata[15:0]);
                        mq.push_back(im_rdata[31:16]);
                    end
                    m_fetch = m_fetch + 32'd4;
                end
            end
            if (!m_pend && m_init && mq.size() <= DEPTH - 2) begin
                exp_req_valid = 1'b1;
                exp_req_addr  = m_fetch;
                m_pend        = 1;
            end else begin
                exp_req_valid = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic redirect(input logic [31:0] pc, input logic fence);
        fb_valid = 1'b1;
        fb_spec  = ~fence;
        fb_fence = fence;
        fb_addr  = pc;
        step();
        fb_spec  = 1'b0;
        fb_fence = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] exp, input string name);
        bit got = 0;
        fb_valid = 1'b1;
        fb_spec  = 1'b0;
        fb_fence = 1'b0;
        fb_addr  = pc;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clock);
            if (fb_ready === 1'b1) begin
                check(name, fb_rdata, exp);
                got = 1;
            end
            step();
        end
        if (!got) timeout(name);
    endtask

    task automatic wait_req(input logic [31:0] lo, input logic [31:0] hi, input string name,
                            input logic [31:0] exp);
        bit found = 0;
        logic [31:0] a = 32'd0;
        for (int n = 0; n < 60 && !found; n++) begin
            foreach (req_log[i])
                if (!found && req_log[i] >= lo && req_log[i] <= hi) begin
                    a = req_log[i];
                    found = 1;
                end
            if (!found) step();
        end
        if (found) check(name, a, exp);
        else timeout(name);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit found;
        fb_valid = 1'b1;
        fb_spec  = 1'b1;
        fb_fence = 1'b0;
        fb_addr  = 32'h100;
        repeat (3) step();
        @(negedge clock);
        check("reset_ready", {31'd0, fb_ready}, 32'd0);
        check("reset_rdata", fb_rdata, 32'd0);
        check("reset_imem_valid", {31'd0, im_valid}, 32'd0);
        check("reset_imem_addr", im_addr, 32'd0);
        step();
        fb_valid = 1'b0;
        fb_spec  = 1'b0;
        reset    = 1'b1;
        step();
        step();
        check("imem_instr", {31'd0, im_instr}, 32'd1);
        check("imem_spec", {31'd0, im_spec}, 32'd0);
        check("imem_fence", {31'd0, im_fence}, 32'd0);
        check("imem_wdata", im_wdata, 32'd0);
        check("imem_wstrb", {28'd0, im_wstrb}, 32'd0);

        // Aligned stream
        image[32'h100] = 32'h0000_0013;
        image[32'h104] = 32'h0010_0093;
        redirect(32'h100, 1'b0);
        fetch(32'h100, 32'h0000_0013, "aligned_100");
        fetch(32'h104, 32'h0010_0093, "aligned_104");

        // Compressed then straddling
        image[32'h200] = 32'h0013_4505;
        image[32'h204] = 32'h0000_0001;
        redirect(32'h200, 1'b0);
        fetch(32'h200, 32'h0000_4505, "compressed_200");
        fb_addr = 32'h202;
        @(negedge clock);
        check("straddle_wait", {31'd0, fb_ready}, 32'd0);
        step();
        fetch(32'h202, 32'h0001_0013, "straddle_202");

        // Misaligned redirect
        image[32'h300] = 32'h4505_ABCD;
        req_log.delete();
        redirect(32'h302, 1'b0);
        wait_req(32'h300, 32'h3FF, "misaligned_req", 32'h300);
        fetch(32'h302, 32'h0000_4505, "misaligned_302");
        fetch(32'h304, 32'hA6A2_0317, "misaligned_304");

        // Redirect while the 0x108 request is in flight
        redirect(32'h100, 1'b0);
        fb_valid = 1'b0;
        found = 0;
        for (int n = 0; n < 60 && !found; n++) begin
            @(negedge clock);
            if (im_valid && im_addr == 32'h108) found = 1;
            step();
        end
        if (!found) timeout("inflight_req_108");
        image[32'h400] = 32'h0050_0513;
        redirect(32'h400, 1'b0);
        fetch(32'h400, 32'h0050_0513, "inflight_400");
        check("inflight_gap", req_cyc[32'h400] - resp_cyc[32'h108], 32'd1);

        // Full queue
        req_log.delete();
        redirect(32'h600, 1'b0);
        fb_valid = 1'b0;
        repeat (40) step();
        check("full_req_count", count_reqs(32'h600, 32'h63F), 32'd4);
        fb_valid = 1'b1;
        fb_addr  = 32'h604;
        repeat (3) step();
        check("refill_req_count", count_reqs(32'h600, 32'h63F), 32'd5);
        fetch(32'h604, 32'hA3A2_0617, "full_pop_604");

        // Fence flushes and refetches the same PC
        image[32'h500] = 32'h0000_8082;
        redirect(32'h500, 1'b0);
        fetch(32'h500, 32'h0000_8082, "pre_fence_500");
        req_log.delete();
        fb_fence = 1'b1;
        @(negedge clock);
        check("fence_ready", {31'd0, fb_ready}, 32'd0);
        step();
        fb_fence = 1'b0;
        wait_req(32'h500, 32'h500, "fence_refetch", 32'h500);
        fetch(32'h500, 32'h0000_8082, "post_fence_500");

        // Reset in mid-stream
        redirect(32'h100, 1'b0);
        fetch(32'h100, 32'h0000_0013, "rst_pre_100");
        fetch(32'h104, 32'h0010_0093, "rst_pre_104");
        reset = 1'b0;
        @(negedge clock);
        check("rst_mid_ready", {31'd0, fb_ready}, 32'd0);
        check("rst_mid_rdata", fb_rdata, 32'd0);
        check("rst_mid_imem_valid", {31'd0, im_valid}, 32'd0);
        check("rst_mid_imem_addr", im_addr, 32'd0);
        step();
        step();
        reset = 1'b1;
        step();
        redirect(32'h100, 1'b0);
        fetch(32'h100, 32'h0000_0013, "after_reset_100");

        fb_valid = 1'b0;
        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction prefetch buffer sitting directly upstream of the fetch stage, between it and the instruction memory port. It prefetches aligned 32-bit words into a circular queue of 16-bit halfwords, then returns either a full 32-bit instruction or a zero-extended 16-bit compressed one for the PC the fetch stage presents. Misaligned and straddling instructions, redirects (trap/mret/jump via `mem_spec`) and fences are handled internally, so the fetch stage only sees `mem_ready`/`mem_rdata`.

## Interface
- `DEPTH`, 8: queue capacity in halfwords; power of two, ≥ 4.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (`reset == 0` resets).
- `fetchbuffer_in`  in  mem_in_type  request from the fetch stage. Used fields: `mem_valid`, `mem_fence`, `mem_spec`, `mem_addr[31:0]` (the PC). Ignored fields: `mem_instr`, `mem_wdata`, `mem_wstrb`.
- `fetchbuffer_out`  out  mem_out_type  `mem_ready` (instruction valid this cycle), `mem_rdata[31:0]`.
- `imem_in`  out  mem_in_type  request to instruction memory. `mem_instr=1`, `mem_wdata=0`, `mem_wstrb=0`, `mem_spec=0`, `mem_fence=0`; `mem_addr[1:0]=0`.
- `imem_out`  in  mem_out_type  `mem_ready` pulse with `mem_rdata[31:0]`.

## Operation
- State:
  - `buf[DEPTH]` of 16-bit entries.
  - `rptr` and `wptr`, log2(DEPTH) bits, wrapping.
  - `count`, 0..DEPTH.
  - `head_addr`: byte address of `buf[rptr]`.
  - `fetch_addr`: next word to request.
  - `pend`: one request outstanding.
  - `drop`: discard the next response.
  - `skip`: discard the low halfword of the next response.
  - `init`: set after the first redirect.
- Redirect condition: `mem_valid=1` and any of:
  - `mem_spec=1`,
  - `mem_fence=1`,
  - `init=0`,
  - `off = (mem_addr - head_addr)` not in {0, 2, 4}.
- Redirect action:
  - `mem_ready=0`; `count←0`; `rptr←wptr`.
  - `head_addr←mem_addr`; `fetch_addr←{mem_addr[31:2],2'b00}`; `skip←mem_addr[1]`.
  - `drop←pend`; `init←1`.
- Consume (no redirect, `mem_valid=1`):
  - `off/2` entries are popped: `rptr+=off/2`, `head_addr+=off`, `count-=off/2`.
  - Output uses entries `h0=buf[rptr+off/2]` and `h1` (the next entry).
  - If `h0[1:0]==2'b11`: `mem_ready = (count ≥ off/2+2)`, `mem_rdata={h1,h0}`.
  - Else: `mem_ready = (count ≥ off/2+1)`, `mem_rdata={16'h0,h0}`.
  - When `mem_ready=0`, `mem_rdata=0`.
  - If `off/2 > count`, this is a redirect.
- `mem_valid=0`: no pop, `mem_ready=0`.
- Response handling (`imem_out.mem_ready=1`):
  - `pend←0`.
  - If `drop`: clear `drop`, write nothing.
  - Else if `skip`: write `rdata[31:16]` (1 entry), clear `skip`.
  - Else write `rdata[15:0]` then `rdata[31:16]` (2 entries).
  - Non-dropped responses advance `fetch_addr+=4`.
  - A response arriving in a redirect cycle is dropped.
- Request issue: registered `imem_in.mem_valid` is a one-cycle pulse with `mem_addr=fetch_addr`. Issued when all hold after this cycle's updates:
  - `pend=0`,
  - `init=1`,
  - `count ≤ DEPTH-2`.
  - Issuing sets `pend←1`.
- Same-cycle pop and write: `count` nets both changes. The queue never overflows, since issue reserves 2 entries.

## Timing
- Reset values: `mem_ready=0`, `mem_rdata=0`, `imem_in.mem_valid=0`, `imem_in.mem_addr=0`. Also `count=0`, `rptr=wptr=0`, `pend=drop=skip=init=0`, `head_addr=fetch_addr=0`.
- Reset mid-operation clears all state immediately. A response arriving after reset release while `pend=0` is ignored.
- `fetchbuffer_out` is combinational from state plus `fetchbuffer_in`. Data written by a response is visible the following cycle.
- Redirect at cycle T, no request pending: imem request at T+1. Memory latency L ≥ 1 gives response at T+1+L and earliest `mem_ready=1` at T+2+L.
- Redirect with a request pending: the stale response is dropped, and the new request issues the cycle after it.
- Steady state: throughput is one word per (L+1) cycles. Single outstanding request.

## Test plan
- Aligned stream:
  - Redirect to 0x100; memory returns 0x00000013 at 0x100 and 0x00100093 at 0x104.
  - Required: PC 0x100 → `rdata=0x00000013`; PC 0x104 → `0x00100093`, `mem_ready=1` each.
- Compressed and straddling:
  - Word at 0x200 = 0x00134505, word at 0x204 = 0x0000_0001.
  - Required: PC 0x200 → `0x00004505`.
  - PC 0x202 (h0=0x0013, 32-bit) → `mem_ready=0` until 0x204 arrives, then `0x00010013`.
- Misaligned redirect:
  - `mem_spec=1`, PC 0x302. Required: imem request to 0x300; the low halfword is skipped; the first instruction comes from bits [31:16].
- Redirect with a request in flight:
  - Redirect to 0x400 while the 0x108 request is pending. Required: the 0x108 data is never returned; the 0x400 request is issued the cycle after that response.
- Full queue:
  - `mem_valid=0`, DEPTH=8. Required: exactly 4 requests are issued, then `imem_in.mem_valid` stays 0 until a pop.
- Fence and reset:
  - `mem_fence=1` at PC 0x500. Required: queue flush and refetch of 0x500.
  - Deassert-assert `reset` mid-stream. Required: all outputs return to 0 at once.
